// File: rtl/uart_defs.sv
// Shared UART definitions: receiver state encodings, default bit period, pointer wrap helper.
package uart_defs;

   localparam int unsigned DEFAULT_CDIV = 5208;
   localparam int unsigned PTR_W        = 8;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // Advance a ring-buffer pointer, wrapping from size-1 back to 0.
   function automatic logic [PTR_W-1:0] next_p(input logic [PTR_W-1:0] p, input int unsigned size);
      int unsigned n;
      n = (32'(p) + 32'd1) % size;
      return PTR_W'(n);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Ring buffer for received bytes with first-word fall-through read.
module uart_rx_fifo
   import uart_defs::*;
#(
   parameter int unsigned BUFFER_SIZE = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic [7:0] wdata_i,
   input  logic       pop_i,
   output logic       full_o,
   output logic       valid_o,
   output logic [7:0] data_o
);

   localparam int unsigned IDX_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

   logic [7:0]       mem_q [BUFFER_SIZE];
   logic [PTR_W-1:0] rp_q, rp_d;
   logic [PTR_W-1:0] wp_q, wp_d;

   // Status and head-of-queue read, all from the registered pointers.
   always_comb begin
      full_o  = (next_p(wp_q, BUFFER_SIZE) == rp_q);
      valid_o = (rp_q != wp_q);
      data_o  = mem_q[rp_q[IDX_W-1:0]];
   end

   // Pointer advance; full is judged before any same-cycle pop.
   always_comb begin
      wp_d = wp_q;
      rp_d = rp_q;
      if (push_i && !full_o) begin
         wp_d = next_p(wp_q, BUFFER_SIZE);
      end
      if (pop_i && valid_o) begin
         rp_d = next_p(rp_q, BUFFER_SIZE);
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rp_q <= '0;
         wp_q <= '0;
      end else begin
         rp_q <= rp_d;
         wp_q <= wp_d;
      end
   end

   // Storage write; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push_i && !full_o) begin
         mem_q[wp_q[IDX_W-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Buffered 8N1 UART receiver: synchroniser, bit sampler FSM and output ring buffer.
module uart_rx
   import uart_defs::*;
#(
   parameter int unsigned CDIV        = DEFAULT_CDIV,
   parameter int unsigned BUFFER_SIZE = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned HALF_M1 = CDIV / 2 - 1;
   localparam int unsigned BIT_M1  = CDIV - 1;

   rx_state_e   state_q, state_d;
   logic [31:0] clk_cnt_q, clk_cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        rx_meta_q, rx_s_q;
   logic [1:0]  sync_vld_q;
   logic        armed_q, armed_d;
   logic        frame_err_d, overrun_d;
   logic        push_c;
   logic        full_c;

   // Two-flop synchroniser; sync_vld_q marks when rx_s_q holds a real line sample
   // rather than its reset value, so arming cannot come from the reset state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         sync_vld_q <= 2'b00;
         armed_q    <= 1'b0;
      end else begin
         rx_meta_q  <= rx;
         rx_s_q     <= rx_meta_q;
         sync_vld_q <= {sync_vld_q[0], 1'b1};
         armed_q    <= armed_d;
      end
   end

   // Arm once the synchronised line is genuinely seen idle-high.
   always_comb begin
      armed_d = armed_q | (sync_vld_q[1] & rx_s_q);
   end

   // Receiver FSM next-state and frame decisions.
   always_comb begin
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      push_c      = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (armed_q && !rx_s_q) begin
               state_d   = RX_START;
               clk_cnt_d = 32'd0;
            end
         end
         RX_START: begin
            if (clk_cnt_q == 32'(HALF_M1)) begin
               clk_cnt_d = 32'd0;
               bit_cnt_d = 4'd0;
               state_d   = rx_s_q ? RX_IDLE : RX_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 32'd1;
            end
         end
         RX_DATA: begin
            if (clk_cnt_q == 32'(BIT_M1)) begin
               clk_cnt_d = 32'd0;
               shreg_d   = {rx_s_q, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  state_d = RX_STOP;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 32'd1;
            end
         end
         RX_STOP: begin
            if (clk_cnt_q == 32'(BIT_M1)) begin
               clk_cnt_d = 32'd0;
               state_d   = RX_IDLE;
               if (!rx_s_q) begin
                  frame_err_d = 1'b1;
               end else if (full_c) begin
                  overrun_d = 1'b1;
               end else begin
                  push_c = 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   // FSM state, counters and registered status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RX_IDLE;
         clk_cnt_q <= 32'd0;
         bit_cnt_q <= 4'd0;
         shreg_q   <= 8'd0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         frame_err <= frame_err_d;
         overrun   <= overrun_d;
      end
   end

   uart_rx_fifo #(
      .BUFFER_SIZE (BUFFER_SIZE)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_c),
      .wdata_i (shreg_q),
      .pop_i   (ready),
      .full_o  (full_c),
      .valid_o (valid),
      .data_o  (data)
   );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CDIV=16 and a 4-entry buffer.
module tb_uart_rx;

   localparam int unsigned CDIV  = 16;
   localparam int unsigned BUFSZ = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       ready;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   int n_cmp = 0;
   int n_bad = 0;

   // Monitor-owned observations.
   int         cyc       = 0;
   int         fe_cnt    = 0;
   int         ov_cnt    = 0;
   int         valid_cyc = 0;
   int         rise_cyc  = -1;
   logic       prev_valid = 1'b0;
   logic [7:0] got [$];

   always #5 clk = ~clk;

   uart_rx #(
      .CDIV        (CDIV),
      .BUFFER_SIZE (BUFSZ)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs mid-cycle: pulses, valid rise time, and every popped byte.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if (valid) valid_cyc++;
         if (valid && !prev_valid) rise_cyc = cyc;
         if (valid && ready) got.push_back(data);
      end
      prev_valid = valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] got_at(input int i);
      if (i < got.size()) return 32'(got[i]);
      return 32'hFFFF_FFFF;
   endfunction

   // Called just after a posedge; leaves just after a posedge.
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         wait_cyc(CDIV);
      end
   endtask

   task automatic pop_one();
      ready = 1'b1;
      wait_cyc(1);
      ready = 1'b0;
   endtask

   int t0, base, fe0, ov0, v0;
   logic [9:0] rbits;

   initial begin
      rst   = 1'b1;
      rx    = 1'b1;
      ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      wait_cyc(6);
      check("idle_valid", 32'(valid), 32'd0);

      // Single byte with latency measurement.
      ready = 1'b1;
      base  = got.size();
      v0    = valid_cyc;
      t0    = cyc;
      drive_frame(8'hA5, 1'b1);
      rx = 1'b1;
      wait_cyc(10);
      check("single_latency", 32'(rise_cyc - t0), 32'd155);
      check("single_count", 32'(got.size() - base), 32'd1);
      check("single_data", got_at(base), 32'hA5);
      check("single_valid_cycles", 32'(valid_cyc - v0), 32'd1);
      check("single_valid_after", 32'(valid), 32'd0);

      // Back-to-back frames held in the buffer.
      ready = 1'b0;
      ov0   = ov_cnt;
      drive_frame(8'h00, 1'b1);
      drive_frame(8'hFF, 1'b1);
      drive_frame(8'h3C, 1'b1);
      rx = 1'b1;
      wait_cyc(20);
      check("b2b_valid", 32'(valid), 32'd1);
      check("b2b_head", 32'(data), 32'h00);
      base = got.size();
      repeat (3) pop_one();
      check("b2b_rd0", got_at(base), 32'h00);
      check("b2b_rd1", got_at(base + 1), 32'hFF);
      check("b2b_rd2", got_at(base + 2), 32'h3C);
      check("b2b_empty", 32'(valid), 32'd0);
      check("b2b_no_overrun", 32'(ov_cnt - ov0), 32'd0);

      // Overrun on the fourth byte into a three-entry capacity.
      ov0 = ov_cnt;
      drive_frame(8'h11, 1'b1);
      drive_frame(8'h22, 1'b1);
      drive_frame(8'h33, 1'b1);
      check("ovr_none_yet", 32'(ov_cnt - ov0), 32'd0);
      drive_frame(8'h44, 1'b1);
      rx = 1'b1;
      wait_cyc(20);
      check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
      check("ovr_head", 32'(data), 32'h11);
      base = got.size();
      repeat (4) pop_one();
      check("ovr_count", 32'(got.size() - base), 32'd3);
      check("ovr_rd0", got_at(base), 32'h11);
      check("ovr_rd1", got_at(base + 1), 32'h22);
      check("ovr_rd2", got_at(base + 2), 32'h33);
      check("ovr_empty", 32'(valid), 32'd0);

      // Framing error, then a short glitch on the idle line.
      fe0  = fe_cnt;
      ov0  = ov_cnt;
      base = got.size();
      drive_frame(8'h5A, 1'b0);
      rx = 1'b1;
      wait_cyc(40);
      check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
      check("ferr_valid", 32'(valid), 32'd0);
      rx = 1'b0;
      wait_cyc(4);
      rx = 1'b1;
      wait_cyc(40);
      check("glitch_no_ferr", 32'(fe_cnt - fe0), 32'd1);
      check("glitch_no_ovr", 32'(ov_cnt - ov0), 32'd0);
      check("glitch_no_byte", 32'(got.size() - base), 32'd0);
      check("glitch_valid", 32'(valid), 32'd0);

      // Reset during bit 3 of 0x81, released with the line still low.
      ready = 1'b1;
      fe0   = fe_cnt;
      base  = got.size();
      rbits = {1'b1, 8'h81, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = rbits[i];
         if (i == 4) begin
            wait_cyc(6);
            rst = 1'b1;
            wait_cyc(3);
            rst = 1'b0;
            wait_cyc(CDIV - 9);
         end else begin
            wait_cyc(CDIV);
         end
      end
      rx = 1'b1;
      wait_cyc(40);
      check("rst_mid_no_ferr", 32'(fe_cnt - fe0), 32'd0);
      check("rst_mid_no_byte", 32'(got.size() - base), 32'd0);
      drive_frame(8'h7E, 1'b1);
      rx = 1'b1;
      wait_cyc(20);
      check("rst_next_count", 32'(got.size() - base), 32'd1);
      check("rst_next_data", got_at(base), 32'h7E);

      // Ten streamed bytes across pointer wrap-around.
      ov0  = ov_cnt;
      base = got.size();
      for (int k = 1; k <= 10; k++) begin
         drive_frame(8'(k), 1'b1);
      end
      rx = 1'b1;
      wait_cyc(20);
      check("wrap_count", 32'(got.size() - base), 32'd10);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("wrap_rd%0d", k), got_at(base + k), 32'(k + 1));
      end
      check("wrap_no_overrun", 32'(ov_cnt - ov0), 32'd0);
      check("wrap_empty", 32'(valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Buffered UART receiver: 8N1, LSB first, fixed CDIV clocks per bit.
- Deserialises the asynchronous rx line and pushes each good byte into an internal ring buffer.
- Presents bytes to the fabric on a valid/ready interface.
- Counterpart to the team's buffered UART transmitter: same CDIV and BUFFER_SIZE conventions, used for command/loopback input.

Parameters:
- CDIV, 5208, clocks per bit (50_000_000 / 9600); must be >= 4.
- BUFFER_SIZE, 32, ring buffer entries, power of two, <= 256; usable capacity is BUFFER_SIZE-1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: asynchronous, active-high
- rx  input  1  serial line, idle high, asynchronous to clk
- data  output  8  byte at buffer head; meaningful only while valid=1
- valid  output  1  buffer non-empty (rp != wp)
- ready  input  1  consumer accepts; pop on clk edge when valid && ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
- overrun  output  1  one-cycle pulse: good byte dropped because buffer full

Behaviour:
- Reset values:
  - outputs: valid=0, frame_err=0, overrun=0.
  - internal: rp=wp=0, state IDLE, clk_cnt=0, bit_cnt=0, armed=0, sync flops=1.
  - data is don't-care.
- Sync: rx passes through a 2-flop synchroniser (rx_s), reset to 1. All decisions use rx_s.
- armed: set on the first cycle rx_s=1 after reset. Start detection is blocked while armed=0, so a reset in the middle of a frame cannot cause a false start.
- IDLE: if armed && rx_s==0 -> START, clk_cnt<=0.
- START:
  - clk_cnt counts up to CDIV/2-1 (mid start bit).
  - At that count: if rx_s==0 -> DATA (clk_cnt<=0, bit_cnt<=0). Otherwise the start was a glitch -> IDLE, no pulse.
- DATA:
  - At clk_cnt==CDIV-1: clk_cnt<=0, shreg<={rx_s, shreg[7:1]}, bit_cnt<=bit_cnt+1.
  - After the 8th sample -> STOP.
- STOP, at clk_cnt==CDIV-1:
  - rx_s==1 and not full: buffer[wp]<=shreg, wp<=next(wp).
  - rx_s==1 and full: overrun pulses, byte dropped.
  - rx_s==0: frame_err pulses, byte dropped, buffer untouched.
  - All three cases -> IDLE. A new start bit is detectable from the next cycle.
- Pulse timing: frame_err/overrun are registered and assert in the cycle after the STOP decision, for exactly 1 cycle.
- Latency: valid rises the cycle after the STOP-sample edge (registered wp).
  - Total from start falling edge on rx: 2 sync cycles + CDIV/2 + 9*CDIV + 1 clocks.
- Buffer:
  - Pointer width 8 bits. next(p) = (p+1) % BUFFER_SIZE, wrapping from BUFFER_SIZE-1 to 0.
  - full = next(wp)==rp; empty = rp==wp.
  - valid=!empty. data=buffer[rp] (first-word fall-through, combinational read).
  - Pop: valid && ready at clk edge -> rp<=next(rp). ready while empty has no effect.
  - data stays stable while valid && !ready.
- Simultaneous push and pop when full: full is evaluated before the pop, so the byte is dropped and overrun pulses.
- Simultaneous push and pop otherwise: both take effect; occupancy is unchanged.
- Reset mid-operation:
  - Frame in progress is abandoned and buffer contents are lost (pointers cleared).
  - Receiver re-arms only after rx_s is seen high.
- Counters: clk_cnt 32-bit, bit_cnt 4-bit. No arithmetic overflow is possible within a frame.

Decomposition:
- Shared package/include uart_defs holds:
  - receiver state encodings RX_IDLE=0, RX_START=1, RX_DATA=2, RX_STOP=3
  - default CDIV
  - the next_p pointer-wrap helper, shared with the transmitter.
- One sub-module, uart_rx_fifo: ring buffer with push/full/pop/valid/data, plus the pointer logic.
- The line sampler/FSM stays in uart_rx.

Test Plan (CDIV=16, BUFFER_SIZE=4 in sim):
- Single byte: drive 8N1 frame 0xA5 at 16 clk/bit, ready=1 -> valid rises 2+8+144+1 clocks after the start edge, data=0xA5, popped next edge, valid=0.
- Back-to-back: frames 0x00, 0xFF, 0x3C with no idle gap, ready=0 -> after the third frame valid=1, and reads give 0x00, 0xFF, 0x3C in order.
- Overrun: 4 good frames (0x11..0x44), ready=0 -> 0x11..0x33 stored, overrun pulses once after the 4th frame, data=0x11.
- Framing/glitch:
  - frame 0x5A with stop bit low -> frame_err 1-cycle pulse, valid stays 0.
  - 4-clock low glitch on idle line -> no pulse, no byte.
- Reset: assert rst during bit 3 of 0x81, release with rx still low mid-frame -> no byte and no frame_err. The next clean frame 0x7E is received correctly.
- Wrap: 10 frames 0x01..0x0A with ready=1 -> each byte is output once, in order, across pointer wrap-around, and overrun never asserts.
